// File: rtl/sample_collector_pkg.sv
// ============================================================================
// Module   : sample_collector_pkg
// Purpose  : Shared types, constants and helpers for the sample collector.
//            Holds the FSM state enum, the Galois LFSR feedback mask, the
//            per-lane seed multiplier and the lane-count / seeding helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sample_collector_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // x^32 + x^22 + x^2 + x + 1 : low-order terms of the polynomial, applied
   // as the feedback mask of a left-shifting Galois LFSR (multiply by x mod p).
   localparam logic [31:0] LFSR_POLY     = 32'h0040_0007;

   // Golden-ratio constant used to decorrelate the lane seeds.
   localparam logic [31:0] LANE_SEED_MUL = 32'h9E37_79B9;

   function automatic int lane_count(input int vec_w);
      return (vec_w + 31) / 32;
   endfunction

   // An all-zero state would lock the LFSR, so it is replaced by 1.
   function automatic logic [31:0] lane_seed(input logic [31:0] seed, input int k);
      logic [31:0] s;
      s = seed ^ (32'(k) * LANE_SEED_MUL);
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[31] ? ((s << 1) ^ LFSR_POLY) : (s << 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
// Module   : sample_fifo
// Purpose  : Synchronous FIFO for accepted samples. Supports simultaneous
//            push and pop when full; flush empties it and beats push/pop.
// Ports    : clk, rst_n (async active-low), flush_i, push_i, data_i, pop_i,
//            data_o (head entry), full_o, empty_o
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_pop;
   logic             do_push;

   // Extra pointer MSB distinguishes full from empty.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible behind the pointers.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

`default_nettype wire

// File: rtl/sample_collector.sv
// ============================================================================
// Module   : sample_collector
// Purpose  : Generates pseudo-random candidate vectors from parallel Galois
//            LFSR lanes, tests each against an external combinational
//            checker (sat_i) and buffers accepted ones until target_i
//            samples have been collected and drained.
// Ports    : clk, rst_n, start_i, abort_i, target_i, cand_o, sat_i,
//            smp_valid_o/smp_data_o/smp_ready_i (sample stream),
//            busy_o, done_o; trials_o/rejects_o when stats are enabled.
// Config   : define SAMPLE_COLLECTOR_STATS_EN to add trial/reject counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_collector
   import sample_collector_pkg::*;
#(
   parameter int          VEC_W      = 320,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] SEED       = 32'hACE1_2345
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [15:0]      target_i,
   output logic [VEC_W-1:0] cand_o,
   input  logic             sat_i,
   output logic             smp_valid_o,
   output logic [VEC_W-1:0] smp_data_o,
   input  logic             smp_ready_i,
`ifdef SAMPLE_COLLECTOR_STATS_EN
   output logic [31:0]      trials_o,
   output logic [31:0]      rejects_o,
`endif
   output logic             busy_o,
   output logic             done_o
);

   localparam int LANES = lane_count(VEC_W);

   state_t            state_q;
   logic [15:0]       target_q;
   logic [15:0]       acc_cnt_q;
   logic [LANES*32-1:0] lanes;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              trial;
   logic              push;
   logic              start_ok;
   logic              flush;

   assign smp_valid_o = !fifo_empty;
   assign pop         = smp_valid_o && smp_ready_i;
   // A pop in the same cycle frees a slot, so a full FIFO still allows a trial.
   assign trial       = (state_q == ST_RUN) && !abort_i && (!fifo_full || pop);
   assign push        = trial && sat_i;
   assign start_ok    = start_i && !abort_i &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign flush       = abort_i || start_ok;

   // ---------------------------------------------------------------- lanes
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam logic [31:0] LANE_SEED = lane_seed(SEED, k);
      logic [31:0] lane_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)     lane_q <= LANE_SEED;
         else if (trial) lane_q <= lfsr_next(lane_q);
      end

      assign lanes[k*32 +: 32] = lane_q;
   end

   assign cand_o = lanes[VEC_W-1:0];

   // ----------------------------------------------------------------- fifo
   sample_fifo #(
      .WIDTH (VEC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .push_i  (push),
      .data_i  (cand_o),
      .pop_i   (pop),
      .data_o  (smp_data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // ------------------------------------------------------------------ fsm
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         target_q  <= '0;
         acc_cnt_q <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else if (abort_i) begin
         state_q <= ST_IDLE;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  target_q  <= target_i;
                  acc_cnt_q <= '0;
                  if (target_i == 16'd0) begin
                     state_q <= ST_DONE;
                     busy_o  <= 1'b0;
                     done_o  <= 1'b1;
                  end else begin
                     state_q <= ST_RUN;
                     busy_o  <= 1'b1;
                     done_o  <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               if (push) begin
                  acc_cnt_q <= acc_cnt_q + 16'd1;
                  if (acc_cnt_q + 16'd1 == target_q) state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) begin
                  state_q <= ST_DONE;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SAMPLE_COLLECTOR_STATS_EN
   // ---------------------------------------------------------------- stats
   logic [31:0] trials_q;
   logic [31:0] rejects_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trials_q  <= '0;
         rejects_q <= '0;
      end else if (start_ok) begin
         trials_q  <= '0;
         rejects_q <= '0;
      end else if (trial) begin
         if (trials_q != '1)             trials_q  <= trials_q + 32'd1;
         if (!sat_i && rejects_q != '1)  rejects_q <= rejects_q + 32'd1;
      end
   end

   assign trials_o  = trials_q;
   assign rejects_o = rejects_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sample_collector.sv
// ============================================================================
// Module   : tb_sample_collector
// Purpose  : Self-checking bench for sample_collector. A cycle-level
//            reference model (LFSR lanes as polynomial arithmetic, FIFO as a
//            queue) predicts every output; scenario table, hand-written
//            corner sequences and randomized runs drive the DUT.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sample_collector;

   localparam int          VEC_W      = 320;
   localparam int          FIFO_DEPTH = 4;
   localparam logic [31:0] SEED       = 32'hACE1_2345;
   localparam int          LANES      = (VEC_W + 31) / 32;
   // x^22 + x^2 + x + 1 terms, reduced in after a left shift past x^31
   localparam logic [31:0] P_LOW      = (32'h1 << 22) | (32'h1 << 2) | (32'h1 << 1) | 32'h1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start_i, abort_i, sat_i, smp_ready_i;
   logic [15:0]      target_i;
   logic [VEC_W-1:0] cand_o, smp_data_o;
   logic             smp_valid_o, busy_o, done_o;
`ifdef SAMPLE_COLLECTOR_STATS_EN
   logic [31:0]      trials_o, rejects_o;
`endif

   sample_collector #(
      .VEC_W      (VEC_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .SEED       (SEED)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .target_i    (target_i),
      .cand_o      (cand_o),
      .sat_i       (sat_i),
      .smp_valid_o (smp_valid_o),
      .smp_data_o  (smp_data_o),
      .smp_ready_i (smp_ready_i),
`ifdef SAMPLE_COLLECTOR_STATS_EN
      .trials_o    (trials_o),
      .rejects_o   (rejects_o),
`endif
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ----------------------------------------------------- reference model
   int               m_st;      // 0 idle, 1 run, 2 drain, 3 done
   logic [VEC_W-1:0] m_q[$];
   int               m_target, m_acc;
   logic [31:0]      m_lane[LANES];
   longint           m_trials, m_rejects;
   int               sat_mode;  // 0 one, 1 cand bit0, 2 random, 3 alternate, 4 zero
   bit               alt_ph;
   int               n_samples;
   bit               bit0_ok;

   function automatic logic [31:0] mul_x(input logic [31:0] s);
      logic [32:0] w;
      w = {s, 1'b0};
      return w[32] ? (w[31:0] ^ P_LOW) : w[31:0];
   endfunction

   function automatic logic [VEC_W-1:0] model_cand();
      logic [VEC_W-1:0] v;
      v = '0;
      for (int k = 0; k < LANES; k++)
         for (int b = 0; b < 32; b++)
            if (k*32 + b < VEC_W) v[k*32 + b] = m_lane[k][b];
      return v;
   endfunction

   task automatic model_reset();
      logic [31:0] s;
      m_st = 0; m_q.delete(); m_target = 0; m_acc = 0;
      m_trials = 0; m_rejects = 0;
      for (int k = 0; k < LANES; k++) begin
         s = SEED ^ (k * 32'h9E37_79B9);
         m_lane[k] = (s == 0) ? 32'h1 : s;
      end
   endtask

   task automatic compare_outputs();
      check("cand_o", cand_o, model_cand());
      check("smp_valid_o", VEC_W'(smp_valid_o), VEC_W'(m_q.size() > 0));
      if (m_q.size() > 0) check("smp_data_o", smp_data_o, m_q[0]);
      check("busy_o", VEC_W'(busy_o), VEC_W'(m_st == 1 || m_st == 2));
      check("done_o", VEC_W'(done_o), VEC_W'(m_st == 3));
`ifdef SAMPLE_COLLECTOR_STATS_EN
      check("trials_o", VEC_W'(trials_o), VEC_W'(m_trials[31:0]));
      check("rejects_o", VEC_W'(rejects_o), VEC_W'(m_rejects[31:0]));
`endif
   endtask

   // Apply one cycle of inputs, advance the model, clock, compare.
   task automatic cycle(input bit start, input bit abort, input int tgt, input bit ready);
      logic [VEC_W-1:0] c;
      bit sat, pop, full, trial, push;
      int sz;
      c = model_cand();
      case (sat_mode)
         0:       sat = 1'b1;
         1:       sat = c[0];
         2:       sat = 1'($urandom_range(0, 1));
         3:       sat = alt_ph;
         default: sat = 1'b0;
      endcase
      alt_ph = !alt_ph;
      start_i = start; abort_i = abort; target_i = tgt[15:0];
      smp_ready_i = ready; sat_i = sat;
      if (smp_valid_o && ready) begin
         n_samples++;
         if (!smp_data_o[0]) bit0_ok = 1'b0;
      end
      sz    = m_q.size();
      pop   = (sz > 0) && ready;
      full  = (sz == FIFO_DEPTH);
      trial = (m_st == 1) && !abort && (!full || pop);
      push  = trial && sat;
      if (abort) begin
         m_q.delete();
         m_st = 0;
      end else begin
         if (pop)  void'(m_q.pop_front());
         if (push) m_q.push_back(c);
         case (m_st)
            0, 3: if (start) begin
               m_q.delete(); m_target = tgt; m_acc = 0;
               m_trials = 0; m_rejects = 0;
               m_st = (tgt == 0) ? 3 : 1;
            end
            1: if (push) begin
               m_acc++;
               if (m_acc == m_target) m_st = 2;
            end
            2: if (sz == 0) m_st = 3;
            default: ;
         endcase
      end
      if (trial) begin
         for (int k = 0; k < LANES; k++) m_lane[k] = mul_x(m_lane[k]);
         if (m_trials < 64'hFFFF_FFFF) m_trials++;
         if (!sat && m_rejects < 64'hFFFF_FFFF) m_rejects++;
      end
      @(posedge clk); #1;
      compare_outputs();
   endtask

   // Start a run and clock it until done_o or the budget runs out.
   task automatic run_to_done(input int tgt, input int ready_mode);
      bit seen;
      seen = 0;
      cycle(1, 0, tgt, 1'b1);
      for (int i = 0; i < 400; i++) begin
         if (done_o) begin seen = 1; break; end
         cycle(0, 0, tgt, ready_mode == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      check("run_done_within_budget", VEC_W'(seen), VEC_W'(1));
   endtask

   typedef struct {
      int tgt;
      int ready_mode;  // 0 always ready, 1 random
      int smode;
      int exp_samples;
      bit want_bit0;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{tgt: 5, ready_mode: 0, smode: 0, exp_samples: 5, want_bit0: 0};
      tbl[1] = '{tgt: 0, ready_mode: 0, smode: 0, exp_samples: 0, want_bit0: 0};
      tbl[2] = '{tgt: 3, ready_mode: 0, smode: 1, exp_samples: 3, want_bit0: 1};
      tbl[3] = '{tgt: 6, ready_mode: 1, smode: 2, exp_samples: 6, want_bit0: 0};
      tbl[4] = '{tgt: 1, ready_mode: 0, smode: 0, exp_samples: 1, want_bit0: 0};

      start_i = 0; abort_i = 0; sat_i = 0; smp_ready_i = 0; target_i = '0;
      sat_mode = 0; alt_ph = 0; n_samples = 0; bit0_ok = 1;
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_outputs();                      // reset state
      rst_n = 1;
      @(posedge clk); #1;
      compare_outputs();

      // ---- scenario table
      for (int i = 0; i < 5; i++) begin
         sat_mode = tbl[i].smode; n_samples = 0; bit0_ok = 1;
         run_to_done(tbl[i].tgt, tbl[i].ready_mode);
         check("tbl_samples", VEC_W'(n_samples), VEC_W'(tbl[i].exp_samples));
         check("tbl_busy_at_done", VEC_W'(busy_o), VEC_W'(0));
         if (tbl[i].want_bit0) check("tbl_bit0_set", VEC_W'(bit0_ok), VEC_W'(1));
      end

      // ---- backpressure: 4 pushes, LFSR holds, then 8 in order
      sat_mode = 0; n_samples = 0;
      cycle(1, 0, 8, 1'b0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 8, 1'b0);
      check("bp_valid_held", VEC_W'(smp_valid_o), VEC_W'(1));
      check("bp_busy", VEC_W'(busy_o), VEC_W'(1));
      for (int i = 0; i < 60 && !done_o; i++) cycle(0, 0, 8, 1'b1);
      check("bp_samples", VEC_W'(n_samples), VEC_W'(8));
      check("bp_done", VEC_W'(done_o), VEC_W'(1));

      // ---- abort with two samples buffered
      n_samples = 0;
      cycle(1, 0, 8, 1'b0);
      cycle(0, 0, 8, 1'b0);
      cycle(0, 0, 8, 1'b0);
      check("abort_pre_valid", VEC_W'(smp_valid_o), VEC_W'(1));
      cycle(0, 1, 8, 1'b0);
      check("abort_valid", VEC_W'(smp_valid_o), VEC_W'(0));
      check("abort_busy", VEC_W'(busy_o), VEC_W'(0));
      cycle(0, 0, 8, 1'b1);
      cycle(0, 0, 8, 1'b1);
      check("abort_no_samples", VEC_W'(n_samples), VEC_W'(0));

`ifdef SAMPLE_COLLECTOR_STATS_EN
      // ---- stats with alternating checker result
      sat_mode = 3; alt_ph = 1;
      run_to_done(4, 0);
      check("stats_rejects_rel", VEC_W'(rejects_o), VEC_W'(trials_o - 32'd4));
      check("stats_trials_range", VEC_W'(trials_o == 32'd7 || trials_o == 32'd8), VEC_W'(1));
`endif

      // ---- reset mid-run discards buffered samples
      sat_mode = 0;
      cycle(1, 0, 8, 1'b0);
      cycle(0, 0, 8, 1'b0);
      cycle(0, 0, 8, 1'b0);
      #2 rst_n = 0;
      model_reset();
      #1;
      compare_outputs();
      @(posedge clk); #1;
      rst_n = 1;
      cycle(0, 0, 0, 1'b1);

      // ---- randomized runs with random ready, sat, stray starts and aborts
      for (int r = 0; r < 12; r++) begin
         int t, ab;
         sat_mode = 2;
         t  = $urandom_range(0, 12);
         ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : -1;
         cycle(1, 0, t, 1'($urandom_range(0, 1)));
         for (int i = 0; i < 400; i++) begin
            if (done_o) break;
            if (i == ab) begin
               cycle(0, 1, t, 1'($urandom_range(0, 1)));
               break;
            end
            cycle(($urandom_range(0, 15) == 0), 0, $urandom_range(0, 12), 1'($urandom_range(0, 1)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
